// File: rtl/pulse_conditioner.sv
// pulse_conditioner: per-channel input conditioning ahead of the correlator core.
// Each channel synchronises an asynchronous active-low pulse input and detects a
// selectable event (falling, rising, both edges or level). A holdoff dead-time
// rejects events that arrive too soon after an accepted one. The result is then
// delayed by a programmable number of clocks so the array can be skew-aligned.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   pulse_in     raw asynchronous inputs, active-low (idle high)
//   cfg_we       one-cycle configuration write strobe
//   cfg_channel  channel addressed by the write
//   cfg_mode     00 falling, 01 rising, 10 both edges, 11 level
//   cfg_delay    output delay in clocks (clamped to MAX_DELAY-1)
//   cfg_holdoff  dead-time in clocks after an accepted event
//   cfg_err      one-cycle flag: write addressed a nonexistent channel
//   pulse_out    conditioned events, active-high, registered
//   suppressed   one-cycle flag: event rejected by holdoff (undelayed)
module pulse_conditioner #(
   parameter int unsigned NUM_INPUTS   = 12,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned MAX_DELAY    = 16,
   parameter int unsigned DELAY_BITS   = 4,
   parameter int unsigned HOLDOFF_BITS = 4,
   parameter int unsigned CHAN_BITS    = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_INPUTS-1:0]   pulse_in,
   input  logic                    cfg_we,
   input  logic [CHAN_BITS-1:0]    cfg_channel,
   input  logic [1:0]              cfg_mode,
   input  logic [DELAY_BITS-1:0]   cfg_delay,
   input  logic [HOLDOFF_BITS-1:0] cfg_holdoff,
   output logic                    cfg_err,
   output logic [NUM_INPUTS-1:0]   pulse_out,
   output logic [NUM_INPUTS-1:0]   suppressed
);

   localparam int unsigned GUARD_INIT = SYNC_STAGES + 1;
   localparam int unsigned GUARD_BITS = $clog2(SYNC_STAGES + 2);

   localparam logic [1:0] MODE_FALL  = 2'b00;
   localparam logic [1:0] MODE_RISE  = 2'b01;
   localparam logic [1:0] MODE_BOTH  = 2'b10;
   localparam logic [1:0] MODE_LEVEL = 2'b11;

   logic [SYNC_STAGES-1:0]  sync_q    [NUM_INPUTS];
   logic [SYNC_STAGES-1:0]  sync_d    [NUM_INPUTS];
   logic [1:0]              mode_q    [NUM_INPUTS];
   logic [1:0]              mode_d    [NUM_INPUTS];
   logic [DELAY_BITS-1:0]   delay_q   [NUM_INPUTS];
   logic [DELAY_BITS-1:0]   delay_d   [NUM_INPUTS];
   logic [HOLDOFF_BITS-1:0] holdoff_q [NUM_INPUTS];
   logic [HOLDOFF_BITS-1:0] holdoff_d [NUM_INPUTS];
   logic [HOLDOFF_BITS-1:0] hcnt_q    [NUM_INPUTS];
   logic [HOLDOFF_BITS-1:0] hcnt_d    [NUM_INPUTS];
   logic [MAX_DELAY-1:0]    dline_q   [NUM_INPUTS];
   logic [MAX_DELAY-1:0]    dline_d   [NUM_INPUTS];

   logic [NUM_INPUTS-1:0]   prev_q, prev_d;
   logic [NUM_INPUTS-1:0]   supp_stage_q, supp_stage_d;
   logic [NUM_INPUTS-1:0]   suppressed_q, suppressed_d;
   logic [NUM_INPUTS-1:0]   pulse_out_q, pulse_out_d;
   logic                    cfg_err_q, cfg_err_d;
   logic [GUARD_BITS-1:0]   guard_q, guard_d;

   logic [NUM_INPUTS-1:0]   evt_c, accept_c, supp_c;
   logic                    cfg_valid_c;
   logic [DELAY_BITS-1:0]   cfg_delay_clamped;

   // Clamp only exists when the setting width can express out-of-range delays.
   if (MAX_DELAY < (1 << DELAY_BITS)) begin : g_clamp
      assign cfg_delay_clamped = (cfg_delay >= DELAY_BITS'(MAX_DELAY)) ?
                                 DELAY_BITS'(MAX_DELAY - 1) : cfg_delay;
   end else begin : g_noclamp
      assign cfg_delay_clamped = cfg_delay;
   end

   assign cfg_valid_c = cfg_we && (cfg_channel < CHAN_BITS'(NUM_INPUTS));

   // Event detection and holdoff gating; blanked until the pipeline has flushed its reset value.
   always_comb begin
      evt_c    = '0;
      accept_c = '0;
      supp_c   = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         case (mode_q[i])
            MODE_FALL: evt_c[i] =  prev_q[i] & ~sync_q[i][SYNC_STAGES-1];
            MODE_RISE: evt_c[i] = ~prev_q[i] &  sync_q[i][SYNC_STAGES-1];
            MODE_BOTH: evt_c[i] =  prev_q[i] ^  sync_q[i][SYNC_STAGES-1];
            default:   evt_c[i] = ~sync_q[i][SYNC_STAGES-1];
         endcase
         evt_c[i] = evt_c[i] & (guard_q == '0);
         if (mode_q[i] == MODE_LEVEL) begin
            accept_c[i] = evt_c[i];
         end else if (evt_c[i]) begin
            if (hcnt_q[i] == '0) begin
               accept_c[i] = 1'b1;
            end else begin
               supp_c[i] = 1'b1;
            end
         end
      end
   end

   // Next-state logic; a config write clears the addressed channel's delay line and holdoff.
   always_comb begin
      guard_d      = (guard_q != '0) ? guard_q - GUARD_BITS'(1) : guard_q;
      cfg_err_d    = cfg_we & ~cfg_valid_c;
      prev_d       = '0;
      pulse_out_d  = '0;
      supp_stage_d = supp_c;
      suppressed_d = supp_stage_q;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], pulse_in[i]};
         prev_d[i]    = sync_q[i][SYNC_STAGES-1];
         mode_d[i]    = mode_q[i];
         delay_d[i]   = delay_q[i];
         holdoff_d[i] = holdoff_q[i];
         hcnt_d[i]    = (hcnt_q[i] != '0) ? hcnt_q[i] - HOLDOFF_BITS'(1) : hcnt_q[i];
         if (accept_c[i] && (mode_q[i] != MODE_LEVEL)) begin
            hcnt_d[i] = holdoff_q[i];
         end
         dline_d[i]     = {dline_q[i][MAX_DELAY-2:0], accept_c[i]};
         pulse_out_d[i] = dline_q[i][delay_q[i]];
         if (cfg_valid_c && (cfg_channel == CHAN_BITS'(i))) begin
            mode_d[i]    = cfg_mode;
            delay_d[i]   = cfg_delay_clamped;
            holdoff_d[i] = cfg_holdoff;
            hcnt_d[i]    = '0;
            dline_d[i]   = '0;
         end
      end
   end

   // State registers; reset restores the legacy falling-edge configuration.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            sync_q[i]    <= '1;
            mode_q[i]    <= MODE_FALL;
            delay_q[i]   <= '0;
            holdoff_q[i] <= '0;
            hcnt_q[i]    <= '0;
            dline_q[i]   <= '0;
         end
         prev_q       <= '1;
         supp_stage_q <= '0;
         suppressed_q <= '0;
         pulse_out_q  <= '0;
         cfg_err_q    <= 1'b0;
         guard_q      <= GUARD_BITS'(GUARD_INIT);
      end else begin
         for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            sync_q[i]    <= sync_d[i];
            mode_q[i]    <= mode_d[i];
            delay_q[i]   <= delay_d[i];
            holdoff_q[i] <= holdoff_d[i];
            hcnt_q[i]    <= hcnt_d[i];
            dline_q[i]   <= dline_d[i];
         end
         prev_q       <= prev_d;
         supp_stage_q <= supp_stage_d;
         suppressed_q <= suppressed_d;
         pulse_out_q  <= pulse_out_d;
         cfg_err_q    <= cfg_err_d;
         guard_q      <= guard_d;
      end
   end

   assign pulse_out  = pulse_out_q;
   assign suppressed = suppressed_q;
   assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Testbench for pulse_conditioner: directed scenarios plus randomized traffic,
// checked against an event-time reference model through an expectation queue.
module tb_pulse_conditioner;

   localparam int NI = 12;
   localparam int MAXD = 16;

   logic          clk;
   logic          rst;
   logic [NI-1:0] pulse_in;
   logic          cfg_we;
   logic [3:0]    cfg_channel;
   logic [1:0]    cfg_mode;
   logic [3:0]    cfg_delay;
   logic [3:0]    cfg_holdoff;
   logic          cfg_err;
   logic [NI-1:0] pulse_out;
   logic [NI-1:0] suppressed;

   int checks = 0;
   int failures = 0;

   pulse_conditioner dut (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in),
      .cfg_we      (cfg_we),
      .cfg_channel (cfg_channel),
      .cfg_mode    (cfg_mode),
      .cfg_delay   (cfg_delay),
      .cfg_holdoff (cfg_holdoff),
      .cfg_err     (cfg_err),
      .pulse_out   (pulse_out),
      .suppressed  (suppressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NI-1:0] po;
      logic [NI-1:0] sup;
      logic          err;
   } exp_t;

   exp_t exp_q[$];

   // Reference model in event time: t counts edges since reset release; the
   // event judged at edge t compares input samples t-1 (current) and t-2 (previous).
   // Accepted events emerge at edge t+2+delay, rejections flag at edge t+2.
   int            t;
   logic [NI-1:0] x1, x2;
   int            m_mode [NI];
   int            m_delay[NI];
   int            m_hold [NI];
   int            m_next [NI];
   int            pend   [NI][$];
   int            spend  [NI][$];

   always @(posedge clk) begin : model
      exp_t e;
      int   keep[$];
      int   c;
      logic s, p, evt;
      e = '0;
      if (rst) begin
         t  = 0;
         x1 = '1;
         x2 = '1;
         for (int i = 0; i < NI; i++) begin
            m_mode[i] = 0; m_delay[i] = 0; m_hold[i] = 0; m_next[i] = 0;
            pend[i].delete();
            spend[i].delete();
         end
      end else begin
         t++;
         if (cfg_we) begin
            if (int'(cfg_channel) < NI) begin
               c = int'(cfg_channel);
               m_mode[c]  = int'(cfg_mode);
               m_delay[c] = (int'(cfg_delay) > MAXD - 1) ? MAXD - 1 : int'(cfg_delay);
               m_hold[c]  = int'(cfg_holdoff);
               m_next[c]  = t;
               keep.delete();
               foreach (pend[c][k]) if (pend[c][k] <= t) keep.push_back(pend[c][k]);
               pend[c] = keep;
            end else begin
               e.err = 1'b1;
            end
         end
         for (int i = 0; i < NI; i++) begin
            s = x1[i];
            p = x2[i];
            case (m_mode[i])
               0: evt = p && !s;
               1: evt = !p && s;
               2: evt = p != s;
               default: evt = !s;
            endcase
            if (t >= 3 && evt) begin
               if (m_mode[i] == 3) begin
                  pend[i].push_back(t + 2 + m_delay[i]);
               end else if (t >= m_next[i]) begin
                  pend[i].push_back(t + 2 + m_delay[i]);
                  m_next[i] = t + m_hold[i] + 1;
               end else begin
                  spend[i].push_back(t + 2);
               end
            end
            keep.delete();
            foreach (pend[i][k]) begin
               if (pend[i][k] == t) e.po[i] = 1'b1;
               else keep.push_back(pend[i][k]);
            end
            pend[i] = keep;
            keep.delete();
            foreach (spend[i][k]) begin
               if (spend[i][k] == t) e.sup[i] = 1'b1;
               else keep.push_back(spend[i][k]);
            end
            spend[i] = keep;
         end
         x2 = x1;
         x1 = pulse_in;
      end
      exp_q.push_back(e);
   end

   // Monitor: the outputs are presented every cycle, one expectation per edge.
   always begin : monitor
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (pulse_out !== e.po) begin
            failures++;
            $display("FAIL pulse_out at %0t got=%h exp=%h", $time, pulse_out, e.po);
         end
         checks++;
         if (suppressed !== e.sup) begin
            failures++;
            $display("FAIL suppressed at %0t got=%h exp=%h", $time, suppressed, e.sup);
         end
         checks++;
         if (cfg_err !== e.err) begin
            failures++;
            $display("FAIL cfg_err at %0t got=%b exp=%b", $time, cfg_err, e.err);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cfg_write(input int ch, input int mode, input int dly, input int hold);
      @(negedge clk);
      cfg_we      = 1'b1;
      cfg_channel = 4'(ch);
      cfg_mode    = 2'(mode);
      cfg_delay   = 4'(dly);
      cfg_holdoff = 4'(hold);
      @(negedge clk);
      cfg_we      = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pulse_in = '1;
      cfg_we = 1'b0;
      cfg_channel = '0;
      cfg_mode = '0;
      cfg_delay = '0;
      cfg_holdoff = '0;
      tick(3);
      rst = 1'b0;
      tick(5);

      // Legacy falling-edge behaviour on channel 0
      pulse_in[0] = 1'b0; tick(5); pulse_in[0] = 1'b1; tick(6);

      // Rising edge with delay 5, then maximum delay 15
      cfg_write(3, 1, 5, 0);
      pulse_in[3] = 1'b0; tick(4); pulse_in[3] = 1'b1; tick(12);
      cfg_write(3, 1, 15, 0);
      pulse_in[3] = 1'b0; tick(3); pulse_in[3] = 1'b1; tick(22);

      // Both edges with holdoff 4, toggling every 2 cycles
      cfg_write(1, 2, 0, 4);
      repeat (10) begin pulse_in[1] = ~pulse_in[1]; tick(2); end
      tick(8);

      // Level mode ignores holdoff
      cfg_write(2, 3, 0, 5);
      pulse_in[2] = 1'b0; tick(7); pulse_in[2] = 1'b1; tick(6);

      // Invalid channel writes
      cfg_write(12, 1, 3, 3);
      cfg_write(15, 2, 1, 1);
      tick(3);

      // Rewrite channel 0 while its pulse is in the delay line
      cfg_write(0, 0, 6, 0);
      pulse_in[0] = 1'b0; pulse_in[5] = 1'b0; tick(2);
      pulse_in[0] = 1'b1; pulse_in[5] = 1'b1; tick(2);
      cfg_write(0, 0, 6, 0);
      tick(12);

      // Randomized traffic with occasional config writes and resets
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < NI; i++)
            if ($urandom_range(3) == 0) pulse_in[i] = ~pulse_in[i];
         cfg_we      = ($urandom_range(15) == 0);
         cfg_channel = 4'($urandom_range(15));
         cfg_mode    = 2'($urandom_range(3));
         cfg_delay   = 4'($urandom_range(15));
         cfg_holdoff = 4'($urandom_range(15));
         rst         = ($urandom_range(199) == 0);
         @(negedge clk);
      end
      cfg_we = 1'b0;
      rst = 1'b0;

      // Reset with pulses in flight, released with channel 0 held low
      pulse_in = '0; tick(2);
      pulse_in = '1; tick(2);
      pulse_in[0] = 1'b0;
      rst = 1'b1; tick(2);
      rst = 1'b0; tick(6);
      pulse_in[0] = 1'b1; tick(4);
      pulse_in[0] = 1'b0; tick(2);
      pulse_in[0] = 1'b1; tick(25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
